// File: rtl/wb_pkg.sv
// Shared Wishbone types for the command-stream initiator.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbi_state_t;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } wb_cmd_t;

endpackage

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one command in, one single-beat WB cycle out,
// one response back (read data or timeout error). At most one transaction in flight.
module wb_cmd_initiator
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  wbi_state_t       state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  wb_cmd_t          cmd_q, cmd_d;
  logic             cyc_q, cyc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          cmd_d.we  = cmd_we;
          cmd_d.adr = cmd_adr;
          cmd_d.dat = cmd_dat;
          cmd_d.sel = cmd_sel;
          cyc_d     = 1'b1;
          state_d   = BUS;
        end
      end
      BUS: begin
        // An ack on the last permitted cycle still completes the transfer normally.
        if (wbm_ack_i) begin
          rsp_dat_d   = cmd_q.we ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          cnt_d       = '0;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          cnt_d       = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cmd_q.we;
  assign wbm_adr_o = cmd_q.adr;
  assign wbm_dat_o = cmd_q.dat;
  assign wbm_sel_o = cmd_q.sel;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator: directed vector table, hand-written
// reset/stray-ack sequences, and randomized transactions against a behavioural model.
module tb_wb_cmd_initiator;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  int total = 0;
  int bad   = 0;

  wb_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_delay;  // wait states before ack; >= TO means the slave never acks
    logic [31:0] rdata;
    int          hold;       // cycles rsp_ready stays low once the response is up
    bit          junk;       // keep cmd_valid high with garbage while busy
    bit          exp_err;
    logic [31:0] exp_dat;
    int          exp_stb;    // cycles stb is seen high
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // All driving and sampling happens at the falling edge.
  task automatic run_txn(input string tag, input vec_t v);
    int          stb_cnt;
    int          k;
    bit          done;
    bit          ok;
    logic [31:0] hold_dat;
    logic        hold_err;
    check({tag, " ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    cmd_sel   = v.sel;
    @(posedge clk); @(negedge clk);
    if (v.junk) begin
      cmd_we  = ~v.we;
      cmd_adr = $urandom;
      cmd_dat = $urandom;
      cmd_sel = 4'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    stb_cnt = 0;
    k = 0;
    done = 1'b0;
    while (!done) begin
      if (wbm_stb_o) begin
        stb_cnt++;
        ok = wbm_cyc_o && (wbm_we_o == v.we) && (wbm_adr_o == v.adr) &&
             (wbm_dat_o == v.dat) && (wbm_sel_o == v.sel) && !cmd_ready && !rsp_valid;
        check({tag, " bus_hold"}, 32'(ok), 32'd1);
        wbm_ack_i = (k == v.ack_delay);
        wbm_dat_i = (k == v.ack_delay) ? v.rdata : $urandom;
        k++;
        @(posedge clk); @(negedge clk);
        wbm_ack_i = 1'b0;
        if (k > 40) begin
          total++;
          bad++;
          $display("FAIL %s timeout_budget: stb still high after %0d cycles, expected <= %0d",
                   tag, k, TO);
          done = 1'b1;
        end
      end else begin
        done = 1'b1;
      end
    end
    check({tag, " stb_cycles"}, 32'(stb_cnt), 32'(v.exp_stb));
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({tag, " rsp_dat"}, rsp_dat, v.exp_dat);
    check({tag, " cyc_low"}, 32'(wbm_cyc_o), 32'd0);
    hold_dat = v.exp_dat;
    hold_err = v.exp_err;
    for (int i = 0; i < v.hold; i++) begin
      wbm_ack_i = $urandom_range(0, 1);
      @(posedge clk); @(negedge clk);
      wbm_ack_i = 1'b0;
      ok = rsp_valid && (rsp_dat == hold_dat) && (rsp_err == hold_err) &&
           !cmd_ready && !wbm_stb_o;
      check({tag, " backpressure_stable"}, 32'(ok), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, " no_early_accept"}, 32'(wbm_stb_o), 32'd0);
    cmd_valid = 1'b0;
    $display("txn %s we=%0b adr=%h dat=%h sel=%h delay=%0d -> err=%0b rdat=%h stb=%0d",
             tag, v.we, v.adr, v.dat, v.sel, v.ack_delay, rsp_err, rsp_dat, stb_cnt);
  endtask

  // Behavioural expectation for one transaction.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err = (v.ack_delay >= TO);
    r.exp_stb = r.exp_err ? TO : v.ack_delay + 1;
    r.exp_dat = (r.exp_err || v.we) ? 32'h0 : v.rdata;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    //          we    adr           dat           sel   dly rdata         hold junk err  exp_dat       stb
    vecs[0] = '{1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF, 2,  32'hDEAD_BEEF, 0,  1'b0, 1'b0, 32'h0,         3};
    vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 0,  32'hA5A5_1234, 0,  1'b0, 1'b0, 32'hA5A5_1234, 1};
    vecs[2] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 99, 32'h1111_2222, 0,  1'b0, 1'b1, 32'h0,         16};
    vecs[3] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 15, 32'h1357_9BDF, 0,  1'b0, 1'b0, 32'h1357_9BDF, 16};
    vecs[4] = '{1'b0, 32'h4000_0004, 32'h0,         4'h1, 1,  32'hCAFE_F00D, 10, 1'b1, 1'b0, 32'hCAFE_F00D, 2};
    vecs[5] = '{1'b1, 32'h5000_0008, 32'h0BAD_0BAD, 4'hC, 16, 32'h7777_7777, 0,  1'b0, 1'b1, 32'h0,         16};
    vecs[6] = '{1'b1, 32'h6000_000C, 32'h1234_5678, 4'h3, 14, 32'h8888_8888, 2,  1'b1, 1'b0, 32'h0,         15};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("reset rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("reset rsp_dat", rsp_dat, 32'd0);
    check("reset adr", wbm_adr_o, 32'd0);
    check("reset wdat", wbm_dat_o, 32'd0);
    check("reset sel_we", {27'd0, wbm_sel_o, wbm_we_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    // Stray acks while idle must not start anything.
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    wbm_ack_i = 1'b0;
    check("stray_ack cyc", 32'(wbm_cyc_o), 32'd0);
    check("stray_ack rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_ack cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Reset during BUS: cycle dropped, no response, then a fresh command works.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    check("midrst stb_before", 32'(wbm_stb_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    wbm_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wbm_ack_i = 1'b0;
    check("midrst no_rsp", 32'(rsp_valid), 32'd0);
    run_txn("after_rst", vecs[1]);

    // Randomized transactions against the model.
    for (int i = 0; i < 24; i++) begin
      rv.we        = 1'($urandom);
      rv.adr       = $urandom;
      rv.dat       = $urandom;
      rv.sel       = 4'($urandom);
      rv.ack_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 3) : $urandom_range(0, 5);
      rv.rdata     = $urandom;
      rv.hold      = $urandom_range(0, 4);
      rv.junk      = 1'($urandom);
      rv = model(rv);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
